// File: rtl/pattern_det_pkg.sv
// Shared types and helpers for the runtime-configurable pattern detector.
//   state_e    : control FSM states (unconfigured, filling window, running)
//   DefMaxLen  : default maximum pattern length
//   DefCntW    : default match counter width
//   len_mask() : mask with the low 'len' bits set (patterns up to MaskW bits)
package pattern_det_pkg;

  typedef enum logic [1:0] {StUncfg, StFill, StRun} state_e;

  localparam int unsigned DefMaxLen = 16;
  localparam int unsigned DefCntW   = 8;
  localparam int unsigned MaskW     = 32;

  function automatic logic [MaskW-1:0] len_mask(input int unsigned len);
    logic [MaskW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaskW; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pattern_det_dyn_if.sv
// Serial data, configuration and status bundle of the pattern detector.
//   master : control/data source (drives in_*, cfg_*, cnt_clr; reads status)
//   slave  : the detector (reads in_*, cfg_*, cnt_clr; drives match, match_cnt, armed, cfg_err)
interface pattern_det_dyn_if
  import pattern_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned CNT_W   = DefCntW
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_ovl;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               armed;
  logic               cfg_err;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
    input  match, match_cnt, armed, cfg_err
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pat, cfg_len, cfg_ovl, cnt_clr,
    output match, match_cnt, armed, cfg_err
  );

endinterface

// File: rtl/pat_window.sv
// Shift window, fill counter and masked compare of the pattern detector.
//   clk, rst : clock, async active-low reset
//   clr      : clears window and fill counter (wins over shift)
//   shift    : accept bit_in this cycle
//   bit_in   : serial data bit
//   ovl      : overlapping mode; when 0 a hit restarts the fill counter
//   pat, len : active pattern and length
//   hit      : combinational, the accepted bit completes a match
//   full     : combinational, the accepted bit leaves at least len bits in the window
module pat_window
  import pattern_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               bit_in,
  input  logic               ovl,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               hit,
  output logic               full
);

  logic [MAX_LEN-1:0] win_q, win_d, win_shift, mask;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;

  always_comb begin
    mask      = MAX_LEN'(len_mask(32'(len)));
    win_shift = {win_q[MAX_LEN-2:0], bit_in};
    fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    // Compare against the window as it will be after this bit is shifted in.
    full      = shift && (fill_inc >= len);
    hit       = full && (((win_shift ^ pat) & mask) == '0);

    win_d  = win_q;
    fill_d = fill_q;
    if (clr) begin
      win_d  = '0;
      fill_d = '0;
    end else if (shift) begin
      win_d  = win_shift;
      // Non-overlapping: the next match must be built from fresh bits only.
      fill_d = (hit && !ovl) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_det_dyn.sv
// Runtime-configurable serial bit-pattern detector.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of pattern_det_dyn_if (serial input, configuration load,
//         counter clear; registered match pulse, saturating match_cnt,
//         armed and cfg_err status)
module pattern_det_dyn
  import pattern_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DefMaxLen,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic                clk,
  input  logic                rst,
  pattern_det_dyn_if.slave    bus
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic cfg_legal, accept, hit, full;

  assign cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  // A configuration load drops any bit offered in the same cycle.
  assign accept    = bus.in_valid && !bus.cfg_load && (state_q != StUncfg);

  pat_window #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_win (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.cfg_load),
    .shift (accept),
    .bit_in(bus.in_bit),
    .ovl   (ovl_q),
    .pat   (pat_q),
    .len   (len_q),
    .hit   (hit),
    .full  (full)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = err_q;
    match_d = hit;
    cnt_d   = cnt_q;

    if (bus.cfg_load) begin
      if (cfg_legal) begin
        pat_d   = bus.cfg_pat;
        len_d   = bus.cfg_len;
        ovl_d   = bus.cfg_ovl;
        err_d   = 1'b0;
        state_d = StFill;
      end else begin
        pat_d   = '0;
        len_d   = '0;
        ovl_d   = 1'b0;
        err_d   = 1'b1;
        state_d = StUncfg;
      end
    end else if (accept) begin
      if (hit && !ovl_q) begin
        state_d = StFill;
      end else if (full) begin
        state_d = StRun;
      end
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StUncfg;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.armed     = (state_q != StUncfg);
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_pattern_det_dyn.sv
// Self-checking bench for pattern_det_dyn: a vector table, hand-written corner
// sequences and a random phase, all checked against a queue-based model.
// A second instance with a 2-bit counter sees the same stimulus.
module tb_pattern_det_dyn;
  import pattern_det_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pattern_det_dyn_if #(.MAX_LEN(16), .CNT_W(8)) bus ();
  pattern_det_dyn_if #(.MAX_LEN(16), .CNT_W(2)) bus_n ();

  assign bus_n.in_valid = bus.in_valid;
  assign bus_n.in_bit   = bus.in_bit;
  assign bus_n.cfg_load = bus.cfg_load;
  assign bus_n.cfg_pat  = bus.cfg_pat;
  assign bus_n.cfg_len  = bus.cfg_len;
  assign bus_n.cfg_ovl  = bus.cfg_ovl;
  assign bus_n.cnt_clr  = bus.cnt_clr;

  pattern_det_dyn #(.MAX_LEN(16), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  pattern_det_dyn #(.MAX_LEN(16), .CNT_W(2)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  int checks = 0;
  int errors = 0;

  // Reference model: the bits accepted since the last clear, newest at the back.
  bit          q[$];
  bit          m_cfg, m_ovl, m_err, m_match;
  logic [15:0] m_pat;
  int          m_len;
  int unsigned m_cnt;

  typedef struct {
    logic        v, b, load;
    logic [15:0] pat;
    logic [4:0]  len;
    logic        ovl, clr;
    logic        em;
    logic [7:0]  ec;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic v, b, load, input logic [15:0] pat,
                              input logic [4:0] len, input logic ovl, clr, em,
                              input logic [7:0] ec);
    vec_t r;
    r.v = v; r.b = b; r.load = load; r.pat = pat; r.len = len;
    r.ovl = ovl; r.clr = clr; r.em = em; r.ec = ec;
    return r;
  endfunction

  function automatic int unsigned sat(input int unsigned c, input int unsigned mx);
    return (c > mx) ? mx : c;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_cfg = 0; m_ovl = 0; m_err = 0; m_match = 0; m_pat = '0; m_len = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input logic v, b, load, input logic [15:0] pat,
                                     input logic [4:0] len, input logic ovl, clr);
    bit hit;
    hit = 0;
    if (load) begin
      q.delete();
      if (len >= 5'd1 && len <= 5'd16) begin
        m_cfg = 1; m_err = 0; m_pat = pat; m_len = int'(len); m_ovl = ovl;
      end else begin
        m_cfg = 0; m_err = 1;
      end
    end else if (v && m_cfg) begin
      q.push_back(b);
      if (q.size() > 16) void'(q.pop_front());
      if (q.size() >= m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++) begin
          if (q[q.size() - 1 - i] != m_pat[i]) hit = 0;
        end
      end
      if (hit && !m_ovl) q.delete();
    end
    m_match = hit;
    if (clr) m_cnt = 0;
    else if (hit) m_cnt++;
  endfunction

  task automatic compare_all();
    check("match",     32'(bus.match),       32'(m_match));
    check("match_cnt", 32'(bus.match_cnt),   sat(m_cnt, 255));
    check("armed",     32'(bus.armed),       32'(m_cfg));
    check("cfg_err",   32'(bus.cfg_err),     32'(m_err));
    check("n_match",   32'(bus_n.match),     32'(m_match));
    check("n_cnt",     32'(bus_n.match_cnt), sat(m_cnt, 3));
  endtask

  // Drive one cycle of inputs, clock it, then compare #1 after the edge.
  task automatic cycle(input logic v, b, load, input logic [15:0] pat,
                       input logic [4:0] len, input logic ovl, clr);
    bus.in_valid = v; bus.in_bit = b; bus.cfg_load = load; bus.cfg_pat = pat;
    bus.cfg_len = len; bus.cfg_ovl = ovl; bus.cnt_clr = clr;
    @(posedge clk);
    model_step(v, b, load, pat, len, ovl, clr);
    #1;
    compare_all();
  endtask

  task automatic send(input logic b);
    cycle(1'b1, b, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] seq;
    seq = 8'b1101_1011;  // bits sent MSB first: 1,1,0,1,1,0,1,1

    // Overlapping, pattern 11011 len 5.
    tbl.push_back(mk(0, 0, 1, 16'h001B, 5'd5, 1, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 0, 0, 16'h0, 5'd0, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 1, 8'd1));
    tbl.push_back(mk(1, 0, 0, 16'h0, 5'd0, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 1, 8'd2));
    // Non-overlapping, same stimulus, counter cleared with the load.
    tbl.push_back(mk(0, 0, 1, 16'h001B, 5'd5, 0, 1, 0, 8'd0));
    for (int i = 7; i >= 0; i--) begin
      tbl.push_back(mk(1, seq[i], 0, 16'h0, 5'd0, 0, 0, (i == 3), (i <= 3) ? 8'd1 : 8'd0));
    end
    // Length 1 with a 3-cycle gap carrying garbage on in_bit.
    tbl.push_back(mk(0, 0, 1, 16'h0001, 5'd1, 1, 1, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 1, 8'd1));
    tbl.push_back(mk(1, 0, 0, 16'h0, 5'd0, 0, 0, 0, 8'd1));
    tbl.push_back(mk(0, 1, 0, 16'h0, 5'd0, 0, 0, 0, 8'd1));
    tbl.push_back(mk(0, 0, 0, 16'h0, 5'd0, 0, 0, 0, 8'd1));
    tbl.push_back(mk(0, 1, 0, 16'h0, 5'd0, 0, 0, 0, 8'd1));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 1, 8'd2));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 1, 8'd3));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 1, 8'd4));
    tbl.push_back(mk(1, 1, 0, 16'h0, 5'd0, 0, 0, 1, 8'd5));

    model_reset();
    bus.in_valid = 0; bus.in_bit = 0; bus.cfg_load = 0; bus.cfg_pat = '0;
    bus.cfg_len = '0; bus.cfg_ovl = 0; bus.cnt_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_match", 32'(bus.match), 0);
    check("rst_cnt",   32'(bus.match_cnt), 0);
    check("rst_armed", 32'(bus.armed), 0);
    check("rst_err",   32'(bus.cfg_err), 0);
    check("rst_state", 32'(dut.state_q), 32'(StUncfg));
    @(negedge clk);
    rst = 1'b1;

    // Unconfigured: valid bits are ignored.
    repeat (3) send(1'b1);

    foreach (tbl[k]) begin
      cycle(tbl[k].v, tbl[k].b, tbl[k].load, tbl[k].pat, tbl[k].len, tbl[k].ovl, tbl[k].clr);
      check("tbl_match", 32'(bus.match), 32'(tbl[k].em));
      check("tbl_cnt",   32'(bus.match_cnt), 32'(tbl[k].ec));
    end
    check("sat_cnt_w2", 32'(bus_n.match_cnt), 3);

    // Reset after 4 of 5 pattern bits.
    cycle(0, 0, 1, 16'h001B, 5'd5, 1, 0);
    send(1); send(1); send(0); send(1);
    #1 rst = 1'b0;
    #1;
    check("arst_match", 32'(bus.match), 0);
    check("arst_cnt",   32'(bus.match_cnt), 0);
    check("arst_armed", 32'(bus.armed), 0);
    check("arst_err",   32'(bus.cfg_err), 0);
    check("arst_state", 32'(dut.state_q), 32'(StUncfg));
    model_reset();
    #1 rst = 1'b1;
    send(1);
    check("arst_no_match", 32'(bus.match), 0);
    cycle(0, 0, 1, 16'h001B, 5'd5, 1, 0);
    for (int i = 7; i >= 3; i--) send(seq[i]);
    check("reload_match", 32'(bus.match), 1);

    // Illegal lengths, then a legal reload.
    cycle(0, 0, 1, 16'h0001, 5'd0, 1, 0);
    check("ill0_err",   32'(bus.cfg_err), 1);
    check("ill0_armed", 32'(bus.armed), 0);
    repeat (4) begin
      send(1);
      check("ill_no_match", 32'(bus.match), 0);
    end
    cycle(0, 0, 1, 16'h0001, 5'd17, 1, 0);
    check("ill17_err", 32'(bus.cfg_err), 1);
    cycle(0, 0, 1, 16'h0001, 5'd16, 1, 0);
    check("legal_err",   32'(bus.cfg_err), 0);
    check("legal_armed", 32'(bus.armed), 1);

    // cfg_load with in_valid: bit dropped, window empty.
    cycle(1, 1, 1, 16'h0001, 5'd1, 1, 0);
    check("coll_fill",  32'(dut.u_win.fill_q), 0);
    check("coll_match", 32'(bus.match), 0);
    // cnt_clr with a hit: pulse still seen, count cleared.
    send(1);
    cycle(1, 1, 0, 16'h0, 5'd0, 0, 1);
    check("clr_hit_match", 32'(bus.match), 1);
    check("clr_hit_cnt",   32'(bus.match_cnt), 0);

    // Non-overlapping length 1: a match every cycle.
    cycle(0, 0, 1, 16'h0001, 5'd1, 0, 1);
    repeat (3) begin
      send(1);
      check("nov1_b2b", 32'(bus.match), 1);
    end

    // Random phase against the model.
    for (int n = 0; n < 2000; n++) begin
      int unsigned r;
      logic [4:0] len;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        len = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 5'd0 :
              5'($urandom_range(17, 31))) : 5'($urandom_range(1, 6));
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
              16'($urandom), len, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 16'h0, 5'd0,
              1'b0, (r == 99));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_det_dyn.md
# pattern_det_dyn

Runtime-configurable serial bit-pattern detector. It replaces the fixed-width, fixed-pattern detector with one whose pattern, length (1..MAX_LEN) and overlap/non-overlap mode are loaded at run time. It adds an input-valid qualifier, a saturating match counter and a configuration-error flag. It sits on a serial data path, and a control block programs it.

## Interface
- MAX_LEN, 16: maximum pattern length in bits (≥2).
- LEN_W, $clog2(MAX_LEN+1): width of the length field.
- CNT_W, 8: width of the match counter.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies in_bit; bits with in_valid=0 are ignored.
- in_bit  in  1  serial data, oldest bit first.
- cfg_load  in  1  one-cycle strobe that loads cfg_pat, cfg_len and cfg_ovl.
- cfg_pat  in  MAX_LEN  pattern; bit [cfg_len-1] is compared to the oldest bit in the window, bit [0] to the newest.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_ovl  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  registered one-cycle pulse per detection.
- match_cnt  out  CNT_W  saturating count of detections.
- armed  out  1  a valid configuration is loaded (state ≠ UNCFG).
- cfg_err  out  1  the last cfg_load carried an illegal length.

## Operation
- FSM states: UNCFG, FILL, RUN.
- UNCFG (entered after reset):
  - in_valid is ignored; match stays 0.
  - Legal cfg_load → FILL.
- Legal cfg_load, from any state:
  - Latches the pattern, length and mode.
  - Clears the shift window and the fill counter.
  - Clears cfg_err; armed=1; next state FILL.
- Illegal cfg_load (cfg_len=0 or cfg_len>MAX_LEN):
  - Sets cfg_err=1 and moves to UNCFG.
  - The previous configuration is discarded.
- Every accepted bit (in_valid=1 in FILL or RUN):
  - window ← {window[MAX_LEN-2:0], in_bit}.
  - fill ← min(fill+1, MAX_LEN).
- Comparison:
  - Uses the updated window masked to the low cfg_len bits, against cfg_pat masked the same way.
  - Performed only when the updated fill ≥ cfg_len.
- FILL → RUN when the updated fill reaches cfg_len. A compare also happens on that same bit.
- On a hit:
  - match=1 for the following cycle.
  - match_cnt increments, saturating at 2^CNT_W−1.
  - Overlapping mode: stay in RUN; the window is kept.
  - Non-overlapping mode: fill ← 0 and return to FILL. The next match needs cfg_len fresh bits.
- A cycle with no accepted bit, or a miss, produces match=0.
- Priority order:
  1. rst
  2. cfg_load, which wins over a simultaneous in_valid; that bit is dropped
  3. in_valid
- cnt_clr together with a hit: the clear wins, match_cnt=0, and match still pulses.
- cnt_clr does not affect the window, the fill counter or the FSM.
- Reset mid-stream discards the partial window and requires a reload.

## Timing
- Reset values: match=0, match_cnt=0, armed=0, cfg_err=0. Window, fill, pattern and length registers are all 0. State is UNCFG.
- Latency: match is high in the clock cycle right after the edge that accepted the completing bit. This is one edge of latency, with no combinational path from in_bit to match.
- armed and cfg_err update on the edge that samples cfg_load.
- A bit presented in the cycle right after cfg_load is accepted under the new configuration.
- match_cnt updates on the same edge that raises match.
- Sustained throughput: one bit per cycle, and back-to-back match pulses are possible:
  - overlapping mode, every cycle;
  - non-overlapping mode with cfg_len=1, every cycle.

## Structure
- Package pattern_det_pkg holds:
  - the state enum {UNCFG, FILL, RUN};
  - the default MAX_LEN and CNT_W;
  - a function returning the length mask: the low cfg_len bits set.
- Sub-module pat_window holds the MAX_LEN shift register, the fill counter, the clear input and the masked compare. It outputs a hit that is valid in the same cycle as the accepted bit.
- The top level holds the FSM, the configuration registers, the counter and the output registers.

## Test plan
- Overlapping match: load 5'b11011, len 5, ovl=1, then send 1,1,0,1,1,0,1,1 with in_valid held high. Required: match pulses after bits 5 and 8, and match_cnt=2.
- Non-overlapping match: same stimulus with ovl=0. Required: one pulse after bit 5 only, and match_cnt=1.
- Gaps and shortest pattern:
  - Load len 1, pattern 1, ovl=1, send 1,0,1,1 with an in_valid=0 gap of 3 cycles after bit 2, carrying garbage on in_bit. Required: 3 pulses, match_cnt=3.
  - With CNT_W=2, send 5 hits. Required: match_cnt saturates at 3.
- Illegal length: load len 0. Required: cfg_err=1, armed=0, and a stream of 1s gives no match. A following legal load gives cfg_err=0 and armed=1.
- Reset mid-stream: assert rst after 4 of the 5 pattern bits. Required: every output reads 0 asynchronously, and the state is UNCFG. After release, the 5th bit alone does not match, and matching resumes only after a reload.
- Collisions:
  - cfg_load in the same cycle as in_valid: the bit is dropped and fill=0.
  - cnt_clr in the same cycle as a hit: match=1 and match_cnt=0.
